alu_arbiter: RTL and testbench

Shares the single combinational `alu` between two requesters (e.g. the main datapath and a branch/address unit) in the multi-cycle CPU. It accepts per-requester operation requests and latches their operands. It sequences one ALU operation at a time through a three-state FSM and returns a registered result, zero flag and one-cycle done pulse to the granted requester. Opcodes use the `ALU_*` encodings from `constant_values.vh`.

---
 rtl/alu_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Purpose : shares one combinational ALU between two requesters, one operation at a time.
// Latency : req seen at edge N -> y/zero/err valid and done pulsed after edge N+1; one op per 3 cycles.
// Backpr. : no queueing; a requester holds req until it sees its done, losers simply wait in IDLE.
//
// Macro ALU_ARB_RR_EN: defined -> round-robin on contention; undefined -> requester 0 has fixed priority.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req0/1, a0/1, b0/1,    per-requester request level, operands and opcode (sampled only at grant)
//   op0/1
//   done0/1, y0/1,         per-requester completion pulse, held result, zero flag, illegal-op flag
//   zero0/1, err0/1
//   busy                   high while an operation is in EXEC or DONE
//   alu_a, alu_b, alu_ctrl drive the shared combinational ALU
//   alu_y, alu_zero        ALU result and zero flag
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             zero0,
    output logic             zero1,
    output logic             err0,
    output logic             err1,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    // ALU control encodings shared with the alu block
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OFF = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation latched at grant; later input changes cannot disturb it
    typedef struct packed {
        logic             idx;
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } job_t;

    state_t           state_q, state_d;
    job_t             job_q, job_d;
    logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
    logic             zero0_q, zero0_d, zero1_q, zero1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             grant_idx;
    logic             op_legal;
    logic [WIDTH-1:0] res_y;
    logic             res_zero;

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;   // index of the requester granted most recently

    always_comb begin
        grant_idx = ~req0;
        if (req0 && req1) begin
            grant_idx = ~last_q;
        end
    end
`else
    always_comb begin
        grant_idx = ~req0;
    end
`endif

    always_comb begin
        case (job_q.op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    end

    // Illegal ops record zeros so a floating ALU output is never captured
    always_comb begin
        res_y    = op_legal ? alu_y : '0;
        res_zero = op_legal & alu_zero;
    end

    always_comb begin
        state_d  = state_q;
        job_d    = job_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        zero0_d  = zero0_q;
        zero1_d  = zero1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_OFF;
`ifdef ALU_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    job_d.idx = grant_idx;
                    job_d.op  = grant_idx ? op1 : op0;
                    job_d.a   = grant_idx ? a1  : a0;
                    job_d.b   = grant_idx ? b1  : b0;
`ifdef ALU_ARB_RR_EN
                    last_d    = grant_idx;
`endif
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                alu_a    = job_q.a;
                alu_b    = job_q.b;
                alu_ctrl = op_legal ? job_q.op : ALU_OFF;
                if (job_q.idx) begin
                    y1_d    = res_y;
                    zero1_d = res_zero;
                    err1_d  = ~op_legal;
                    done1_d = 1'b1;
                end else begin
                    y0_d    = res_y;
                    zero0_d = res_zero;
                    err0_d  = ~op_legal;
                    done0_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            job_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            zero0_q <= 1'b0;
            zero1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q  <= 1'b1;  // so the first contention goes to requester 0
`endif
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            zero0_q <= zero0_d;
            zero1_q <= zero1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
`ifdef ALU_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign done0 = done0_q;
    assign done1 = done1_q;
    assign y0    = y0_q;
    assign y1    = y1_q;
    assign zero0 = zero0_q;
    assign zero1 = zero1_q;
    assign err0  = err0_q;
    assign err1  = err1_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : directed bench for alu_arbiter with a transaction-level reference model.
// Latency : model expects done two edges after the grant edge, one op per three cycles.
// Backpr. : requesters hold req until their done, as the arbiter expects.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [2:0] T_AND = 3'b000;
    localparam logic [2:0] T_OR  = 3'b001;
    localparam logic [2:0] T_ADD = 3'b010;
    localparam logic [2:0] T_OFF = 3'b011;
    localparam logic [2:0] T_SUB = 3'b110;
    localparam logic [2:0] T_SLT = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0]   op0 = T_OFF, op1 = T_OFF;
    logic         done0, done1, zero0, zero1, err0, err1, busy, alu_zero;
    logic [W-1:0] y0, y1, alu_a, alu_b, alu_y;
    logic [2:0]   alu_ctrl;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .done0(done0), .done1(done1),
        .y0(y0), .y1(y1),
        .zero0(zero0), .zero1(zero1),
        .err0(err0), .err1(err1),
        .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_y(alu_y), .alu_zero(alu_zero)
    );

    // Stand-in for the shared combinational ALU; a recognisable junk value when off
    always_comb begin
        case (alu_ctrl)
            T_AND:   alu_y = alu_a & alu_b;
            T_OR:    alu_y = alu_a | alu_b;
            T_ADD:   alu_y = alu_a + alu_b;
            T_SUB:   alu_y = alu_a - alu_b;
            T_SLT:   alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_y = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_y == '0);

    function automatic bit is_legal(input logic [2:0] op);
        return (op == T_AND) || (op == T_OR) || (op == T_ADD) || (op == T_SUB) || (op == T_SLT);
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op == T_AND) return a & b;
        if (op == T_OR)  return a | b;
        if (op == T_ADD) return a + b;
        if (op == T_SUB) return a - b;
        if (op == T_SLT) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return '0;
    endfunction

    function automatic bit pick(input logic r0, input logic r1, input bit last);
`ifdef ALU_ARB_RR_EN
        if (r0 && r1) return !last;
        return !r0;
`else
        if (last && !last) return 1'b0;
        return !r0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age = -1 no op in flight, 0 operating cycle, 1 completion cycle
    int           m_age;
    bit           m_idx;
    bit           m_last;
    logic [2:0]   m_op;
    logic [W-1:0] m_a, m_b;
    logic [W-1:0] m_y [2];
    bit           m_zero [2];
    bit           m_err [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age     <= -1;
            m_last    <= 1'b1;
            m_y[0]    <= '0;
            m_y[1]    <= '0;
            m_zero[0] <= 1'b0;
            m_zero[1] <= 1'b0;
            m_err[0]  <= 1'b0;
            m_err[1]  <= 1'b0;
        end else if (m_age == 1) begin
            m_age <= -1;
        end else if (m_age == 0) begin
            m_y[m_idx]    <= is_legal(m_op) ? ref_result(m_op, m_a, m_b) : '0;
            m_zero[m_idx] <= is_legal(m_op) && (ref_result(m_op, m_a, m_b) == '0);
            m_err[m_idx]  <= !is_legal(m_op);
            m_age         <= 1;
        end else if (req0 || req1) begin
            m_idx  <= pick(req0, req1, m_last);
            m_last <= pick(req0, req1, m_last);
            m_op   <= pick(req0, req1, m_last) ? op1 : op0;
            m_a    <= pick(req0, req1, m_last) ? a1 : a0;
            m_b    <= pick(req0, req1, m_last) ? b1 : b0;
            m_age  <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("done0", done0, (m_age == 1) && (m_idx == 1'b0));
            check("done1", done1, (m_age == 1) && (m_idx == 1'b1));
            check("busy",  busy,  m_age >= 0);
            check("y0",    y0,    m_y[0]);
            check("y1",    y1,    m_y[1]);
            check("zero0", zero0, m_zero[0]);
            check("zero1", zero1, m_zero[1]);
            check("err0",  err0,  m_err[0]);
            check("err1",  err1,  m_err[1]);
            check("alu_ctrl", alu_ctrl, (m_age == 0 && is_legal(m_op)) ? m_op : T_OFF);
            if (!(m_age == 0 && !is_legal(m_op))) begin
                check("alu_a", alu_a, (m_age == 0) ? m_a : '0);
                check("alu_b", alu_b, (m_age == 0) ? m_b : '0);
            end
        end
    end

    // Issue one operation and wait (bounded) for its done; lat = cycles from grant edge
    task automatic do_op(input bit idx, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit perturb, output int lat);
        @(posedge clk); #1;
        if (idx) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (perturb && c == 1) begin
                a0  = ~a0;
                b0  = b0 + 32'd5;
                op0 = T_SUB;
            end
            if ((!idx && done0) || (idx && done1)) begin
                lat = c;
                break;
            end
        end
        if (idx) req1 = 1'b0; else req0 = 1'b0;
        check("latency", lat, 2);
    endtask

    initial begin
        int lat;
        bit ord [$];
        bit exp_ord [4];

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst y0", y0, 0);
        check("rst busy", busy, 0);
        check("rst alu_ctrl", alu_ctrl, T_OFF);
        check("rst done0", done0, 0);
        check("rst err1", err1, 0);
        rst_n = 1'b1;

        do_op(0, T_ADD, 32'd8, 32'd41, 0, lat);
        check("add y0", y0, 49);
        check("add zero0", zero0, 0);
        check("add err0", err0, 0);
        check("add y1 untouched", y1, 0);

        do_op(1, T_SUB, 32'd8, 32'd8, 0, lat);
        check("sub y1", y1, 0);
        check("sub zero1", zero1, 1);
        check("sub y0 untouched", y0, 49);

        do_op(1, T_SLT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 0, lat);
        check("slt neg y1", y1, 0);
        do_op(1, T_SLT, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 0, lat);
        check("slt pos y1", y1, 1);
        check("slt zero1", zero1, 0);

        do_op(0, T_OFF, 32'd5, 32'd6, 0, lat);
        check("off y0", y0, 0);
        check("off err0", err0, 1);
        do_op(0, 3'b100, 32'd5, 32'd6, 0, lat);
        check("unused4 err0", err0, 1);
        check("unused4 zero0", zero0, 0);
        do_op(0, 3'b101, 32'd0, 32'd0, 0, lat);
        check("unused5 err0", err0, 1);
        do_op(0, T_OR, 32'h0000_00F0, 32'h0000_000F, 0, lat);
        check("or y0", y0, 32'hFF);
        check("or clears err0", err0, 0);

        do_op(0, T_ADD, 32'd8, 32'd41, 1, lat);
        check("perturb y0", y0, 49);

        do_op(1, T_AND, 32'h0000_F0F0, 32'h0000_0FF0, 0, lat);
        check("and y1", y1, 32'h00F0);
        check("and err1", err1, 0);

        // Reset in the middle of an operation
        @(posedge clk); #1;
        req0 = 1'b1; op0 = T_ADD; a0 = 32'd1; b0 = 32'd2;
        @(posedge clk); #1;
        check("pre-rst busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        req0 = 1'b0;
        check("mid-rst busy", busy, 0);
        check("mid-rst done0", done0, 0);
        check("mid-rst y1", y1, 0);
        check("mid-rst alu_a", alu_a, 0);
        check("mid-rst alu_ctrl", alu_ctrl, T_OFF);
        @(posedge clk); #1;
        check("in-rst done0", done0, 0);
        rst_n = 1'b1;
        do_op(1, T_ADD, 32'd3, 32'd4, 0, lat);
        check("post-rst y1", y1, 7);
        check("post-rst y0", y0, 0);

        // Contention: both held for four completions
        @(posedge clk); #1;
        req0 = 1'b1; op0 = T_ADD; a0 = 32'd10; b0 = 32'd20;
        req1 = 1'b1; op1 = T_SUB; a1 = 32'd50; b1 = 32'd8;
        for (int c = 0; c < 40 && ord.size() < 4; c++) begin
            @(posedge clk); #1;
            if (done0) ord.push_back(1'b0);
            if (done1) ord.push_back(1'b1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
`ifdef ALU_ARB_RR_EN
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        check("contend count", ord.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("contend order", (i < ord.size()) ? {31'd0, ord[i]} : 32'd9, {31'd0, exp_ord[i]});
        end
        check("contend y0", y0, 30);
`ifdef ALU_ARB_RR_EN
        check("contend y1", y1, 42);
`else
        check("contend y1 untouched", y1, 7);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
